// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx serializer among NUM_REQ
// byte-stream requesters. A granted requester keeps the serializer until the
// byte flagged req_last has gone out on the line.
// Optional build macro: UART_TX_ARB_TIMEOUT_EN releases a packet lock once it
// has sat idle for TIMEOUT_CYCLES cycles and pulses timeout_err.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   pkt_active,
  output logic                   timeout_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [PTR_W-1:0]   g_idx_q, g_idx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               last_q, last_d;
  logic               pkt_active_d;
  logic [7:0]         tx_data_d;
  logic               accept;
  logic               arb_found;
  logic [PTR_W-1:0]   arb_sel;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;
`endif

  // (base + off) modulo NUM_REQ; off never exceeds NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned k;
    k = 32'(base) + off;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return PTR_W'(k);
  endfunction

  // Next-state, handshake and next-register-value logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant;
    g_idx_d      = g_idx_q;
    rr_ptr_d     = rr_ptr_q;
    last_d       = last_q;
    pkt_active_d = pkt_active;
    tx_data_d    = tx_data;
    req_ready    = '0;
    accept       = 1'b0;
    arb_found    = 1'b0;
    arb_sel      = rr_ptr_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif

    // First valid requester at or after rr_ptr, wrapping.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[wrap_add(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_sel   = wrap_add(rr_ptr_q, i);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d          = '0;
          grant_d[arb_sel] = 1'b1;
          g_idx_d          = arb_sel;
          state_d          = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // A busy serializer here means external misuse: stall acceptance.
        accept             = req_valid[g_idx_q] && !tx_busy;
        req_ready[g_idx_q] = accept;
        if (accept) begin
          tx_data_d    = req_data[8*g_idx_q +: 8];
          last_d       = req_last[g_idx_q];
          pkt_active_d = 1'b1;
          state_d      = ST_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (pkt_active && !req_valid[g_idx_q]) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d    = 1'b1;
            cnt_d        = '0;
            grant_d      = '0;
            pkt_active_d = 1'b0;
            rr_ptr_d     = wrap_add(g_idx_q, 1);
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      ST_START: state_d = ST_WAIT_BUSY;

      // uart_tx registers busy, so it shows up one cycle after tx_start.
      ST_WAIT_BUSY: begin
        if (tx_busy) state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d      = '0;
            pkt_active_d = 1'b0;
            rr_ptr_d     = wrap_add(g_idx_q, 1);
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: state_d = ST_LOAD;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant      <= '0;
      g_idx_q    <= '0;
      rr_ptr_q   <= '0;
      last_q     <= 1'b0;
      pkt_active <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      g_idx_q    <= g_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      pkt_active <= pkt_active_d;
      tx_data    <= tx_data_d;
      tx_start   <= (state_d == ST_START);
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Idle-lock counter and its one-cycle release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timeout_err <= timeout_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
